uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Byte FIFO between uart_rx and ram_rw on the sys_clk domain. It absorbs bursts of received
//  bytes while ram_rw stalls on RAM or UART-TX traffic, so host downloads never lose data.
//  Valid/ready on both sides, first-word-fall-through output, level and almost-full status.
// PARAMETERS
//  DEPTH     16  entries; power of two, >= 2
//  AFULL_LVL 12  almost_full_o asserts when level_o >= AFULL_LVL; 1 <= AFULL_LVL <= DEPTH
// PORTS
//  clk_i          in   1                  sys_clk
//  rst_n_i        in   1                  async active-low reset (sys_rst_n)
//  flush_i        in   1                  sync clear of all contents
//  in_data_i      in   8                  byte from uart_rx
//  in_vld_i       in   1                  in_data_i valid
//  in_rdy_o       out  1                  FIFO can accept (= !full)
//  out_data_o     out  8                  head byte to ram_rw
//  out_vld_o      out  1                  head byte valid (= !empty)
//  out_rdy_i      in   1                  ram_rw consumes head
//  level_o        out  $clog2(DEPTH)+1    occupancy, 0..DEPTH
//  almost_full_o  out  1                  level_o >= AFULL_LVL
//  overflow_o     out  1                  sticky: in_vld_i seen while in_rdy_o=0
// BEHAVIOUR
//  - Reset (async assert, sync release): wr_ptr=rd_ptr=0, level_o=0, in_rdy_o=1, out_vld_o=0,
//    almost_full_o=0, overflow_o=0, out_data_o=8'h00. Storage array is not reset.
//  - Pointers are ADDR_W+1 bits (ADDR_W=$clog2(DEPTH)); index = ptr[ADDR_W-1:0]; MSB toggles on
//    wrap. empty: wr_ptr==rd_ptr. full: indices equal and MSBs differ.
//  - push = in_vld_i & in_rdy_o; pop = out_vld_o & out_rdy_i; both are evaluated on the same edge.
//  - push: mem[wr_idx] <= in_data_i, wr_ptr++. pop: rd_ptr++.
//  - Latency: a byte pushed on edge N is on out_data_o with out_vld_o=1 after edge N (cycle N+1).
//    No combinational in->out bypass, so an empty FIFO never passes data in the push cycle.
//  - out_data_o = mem[rd_idx] when out_vld_o=1, else 8'h00 (deterministic).
//  - Simultaneous push & pop (neither full nor empty): both occur, level_o unchanged.
//    When full: in_rdy_o=0, so only the pop occurs, and in_rdy_o=1 from the next cycle.
//    When empty: out_vld_o=0, so only the push occurs.
//  - level_o = wr_ptr - rd_ptr (modulo 2^(ADDR_W+1)), registered alongside the pointers.
//    in_rdy_o, out_vld_o and almost_full_o are registered or pure decodes of pointer registers;
//    none depends combinationally on in_vld_i or out_rdy_i.
//  - overflow_o: set on any edge with in_vld_i=1 and in_rdy_o=0; cleared only by reset or
//    flush_i. The upstream holds the byte; the flag is diagnostic only.
//  - flush_i=1: pointers, level_o and overflow_o clear on that edge. It overrides a push or pop
//    in the same cycle. Outputs show the empty state the following cycle.
//  - Reset mid-transfer discards all contents. No partial state survives.
//  - Order is strictly preserved; no byte is duplicated or dropped under any vld/rdy pattern.
// TESTING
//  1 Reset, then push 8'hA5 once with out_rdy_i=0 -> next cycle out_vld_o=1, out_data_o=A5,
//    level_o=1. Pop -> out_vld_o=0, level_o=0.
//  2 Push 16 bytes 00..0F with out_rdy_i=0 -> in_rdy_o=0 and level_o=16; almost_full_o=1 from
//    level 12. Hold in_vld_i=1 -> overflow_o=1. Drain -> 00..0F in order.
//  3 Full FIFO, in_vld_i=1 and out_rdy_i=1 together -> one pop only, level 15. The next cycle
//    accepts the push. Continuous streaming 200 bytes -> no loss, order kept, wrap crossed 12x.
//  4 Level 5, push & pop every cycle for 40 cycles -> level_o stays 5, output order matches input.
//  5 Level 9 with overflow_o=1, flush_i=1 together with push -> next cycle level_o=0,
//    out_vld_o=0, overflow_o=0; pushed byte discarded.
//  6 Assert rst_n_i=0 asynchronously mid-stream (between edges) -> outputs hit reset values
//    immediately. After release, first pushed byte 8'h3C appears as head.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between uart_rx (producer), the byte FIFO and ram_rw
// (consumer), plus the FIFO status outputs. The slave modport is the FIFO
// view; the master modport is the surrounding environment view.
interface uart_rx_fifo_if #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 8
);
   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic [DATA_W-1:0] in_data_i;
   logic              in_vld_i;
   logic              in_rdy_o;
   logic [DATA_W-1:0] out_data_o;
   logic              out_vld_o;
   logic              out_rdy_i;
   logic [LVL_W-1:0]  level_o;
   logic              almost_full_o;
   logic              overflow_o;

   modport master (
      output in_data_i, in_vld_i, out_rdy_i,
      input  in_rdy_o, out_data_o, out_vld_o, level_o, almost_full_o, overflow_o
   );

   modport slave (
      input  in_data_i, in_vld_i, out_rdy_i,
      output in_rdy_o, out_data_o, out_vld_o, level_o, almost_full_o, overflow_o
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// Byte FIFO between uart_rx and ram_rw on sys_clk. Absorbs bursts of received
// bytes while ram_rw stalls. First-word-fall-through head, registered level,
// almost-full status and a sticky overflow diagnostic.
module uart_rx_fifo #(
   parameter int DEPTH     = 16,
   parameter int AFULL_LVL = 12,
   parameter int DATA_W    = 8
) (
   input  logic           clk_i,
   input  logic           rst_n_i,
   input  logic           flush_i,
   uart_rx_fifo_if.slave  bus
);
   localparam int ADDR_W = $clog2(DEPTH);
   localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W:0] AFULL_Q = (ADDR_W + 1)'(AFULL_LVL);

   // Pointers carry one extra wrap bit so full and empty are distinguishable
   logic [ADDR_W:0]   wr_ptr;
   logic [ADDR_W:0]   rd_ptr;
   logic [ADDR_W:0]   level;
   logic              overflow;
   logic [DATA_W-1:0] mem [DEPTH];

   logic [ADDR_W-1:0] wr_idx;
   logic [ADDR_W-1:0] rd_idx;
   logic              empty;
   logic              full;
   logic              push;
   logic              pop;

   assign wr_idx = wr_ptr[ADDR_W-1:0];
   assign rd_idx = rd_ptr[ADDR_W-1:0];
   assign empty  = (wr_ptr == rd_ptr);
   assign full   = (wr_idx == rd_idx) && (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

   // Handshakes qualify only against pointer-register decodes, so ready and
   // valid never depend combinationally on the partner's signal
   assign push = bus.in_vld_i & ~full;
   assign pop  = bus.out_rdy_i & ~empty;

   assign bus.in_rdy_o      = ~full;
   assign bus.out_vld_o     = ~empty;
   assign bus.level_o       = level;
   assign bus.almost_full_o = (level >= AFULL_Q);
   assign bus.overflow_o    = overflow;
   // Head byte is forced to zero while empty so the output is deterministic
   assign bus.out_data_o    = empty ? '0 : mem[rd_idx];

   // Control state: pointers, occupancy and sticky overflow; flush wins over push/pop
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else if (flush_i) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   level <= level + PTR_ONE;
            2'b01:   level <= level - PTR_ONE;
            default: level <= level;
         endcase
         if (bus.in_vld_i && full) overflow <= 1'b1;
      end
   end

   // Storage write; array is data only and deliberately left unreset
   always_ff @(posedge clk_i) begin
      if (push && !flush_i) mem[wr_idx] <= bus.in_data_i;
   end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized self-checking bench for uart_rx_fifo. A queue-based reference
// model tracks contents, occupancy and the sticky overflow flag.
module tb_uart_rx_fifo;
   localparam int DEPTH     = 16;
   localparam int AFULL_LVL = 12;
   localparam int DATA_W    = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;

   uart_rx_fifo_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

   uart_rx_fifo #(.DEPTH(DEPTH), .AFULL_LVL(AFULL_LVL), .DATA_W(DATA_W)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .flush_i (flush),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int   n_chk = 0;
   int   n_err = 0;
   logic [7:0] q[$];
   bit   m_ovf = 1'b0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      int n = q.size();
      chk("out_vld", int'(bus.out_vld_o), int'(n != 0));
      chk("out_data", int'(bus.out_data_o), (n != 0) ? int'(q[0]) : 0);
      chk("level", int'(bus.level_o), n);
      chk("in_rdy", int'(bus.in_rdy_o), int'(n < DEPTH));
      chk("afull", int'(bus.almost_full_o), int'(n >= AFULL_LVL));
      chk("overflow", int'(bus.overflow_o), int'(m_ovf));
   endtask

   // One clock: model applies the rules at the edge, outputs checked mid-cycle
   task automatic cycle();
      int  n;
      bit  push, pop;
      @(posedge clk);
      n    = q.size();
      push = bus.in_vld_i && (n < DEPTH);
      pop  = bus.out_rdy_i && (n > 0);
      if (bus.in_vld_i && n == DEPTH) m_ovf = 1'b1;
      if (flush) begin
         q.delete();
         m_ovf = 1'b0;
      end else begin
         if (pop)  void'(q.pop_front());
         if (push) q.push_back(bus.in_data_i);
      end
      @(negedge clk);
      check_all();
   endtask

   task automatic drive(input bit vld, input logic [7:0] d, input bit rdy, input bit fl);
      bus.in_vld_i  = vld;
      bus.in_data_i = d;
      bus.out_rdy_i = rdy;
      flush         = fl;
   endtask

   initial begin
      drive(0, 8'h00, 0, 0);
      #23;
      // Reset state while held
      check_all();
      rst_n = 1'b1;
      @(negedge clk);
      check_all();

      // 1: single push, then pop
      drive(1, 8'hA5, 0, 0); cycle();
      drive(0, 8'h00, 0, 0);
      chk("t1_vld", int'(bus.out_vld_o), 1);
      chk("t1_data", int'(bus.out_data_o), 'hA5);
      chk("t1_level", int'(bus.level_o), 1);
      drive(0, 8'h00, 1, 0); cycle();
      drive(0, 8'h00, 0, 0);
      chk("t1_vld_pop", int'(bus.out_vld_o), 0);
      chk("t1_level_pop", int'(bus.level_o), 0);

      // 2: fill to full, overflow, drain in order
      for (int i = 0; i < 16; i++) begin
         drive(1, 8'(i), 0, 0); cycle();
         if (i == 11) chk("t2_afull12", int'(bus.almost_full_o), 1);
         if (i == 10) chk("t2_afull11", int'(bus.almost_full_o), 0);
      end
      chk("t2_level16", int'(bus.level_o), 16);
      chk("t2_rdy0", int'(bus.in_rdy_o), 0);
      drive(1, 8'hEE, 0, 0); cycle();
      chk("t2_ovf", int'(bus.overflow_o), 1);
      for (int i = 0; i < 16; i++) begin
         drive(0, 8'h00, 0, 0);
         chk("t2_order", int'(bus.out_data_o), i);
         drive(0, 8'h00, 1, 0); cycle();
      end

      // 3: full + simultaneous push/pop -> pop only; then streaming
      for (int i = 0; i < 16; i++) begin drive(1, 8'(8'h40 + i), 0, 0); cycle(); end
      drive(1, 8'h99, 1, 0); cycle();
      chk("t3_level15", int'(bus.level_o), 15);
      chk("t3_rdy1", int'(bus.in_rdy_o), 1);
      drive(1, 8'h99, 0, 0); cycle();
      chk("t3_accept", int'(bus.level_o), 16);
      for (int i = 0; i < 200; i++) begin drive(1, 8'(i), 1, 0); cycle(); end
      drive(0, 8'h00, 1, 0);
      for (int i = 0; i < 20; i++) cycle();
      chk("t3_empty", int'(bus.level_o), 0);

      // 4: hold level 5 under push & pop every cycle
      for (int i = 0; i < 5; i++) begin drive(1, 8'(8'h70 + i), 0, 0); cycle(); end
      for (int i = 0; i < 40; i++) begin
         drive(1, 8'($urandom), 1, 0); cycle();
         chk("t4_level5", int'(bus.level_o), 5);
      end

      // 5: level 9 with overflow, flush together with push
      drive(1, 8'h11, 0, 0);
      for (int i = 0; i < 12; i++) cycle();
      chk("t5_ovf", int'(bus.overflow_o), 1);
      drive(0, 8'h00, 1, 0);
      for (int i = 0; i < 7; i++) cycle();
      chk("t5_level9", int'(bus.level_o), 9);
      drive(1, 8'h5A, 0, 1); cycle();
      drive(0, 8'h00, 0, 0);
      chk("t5_flush_lvl", int'(bus.level_o), 0);
      chk("t5_flush_vld", int'(bus.out_vld_o), 0);
      chk("t5_flush_ovf", int'(bus.overflow_o), 0);
      cycle();

      // Random traffic with occasional flush
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) == 0),
               1'($urandom_range(0, 59) == 0));
         cycle();
      end

      // 6: asynchronous reset between edges mid-stream
      for (int i = 0; i < 6; i++) begin drive(1, 8'($urandom), 0, 0); cycle(); end
      #2 rst_n = 1'b0;
      #1;
      q.delete();
      m_ovf = 1'b0;
      drive(0, 8'h00, 0, 0);
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
      check_all();
      drive(1, 8'h3C, 0, 0); cycle();
      drive(0, 8'h00, 0, 0);
      chk("t6_head", int'(bus.out_data_o), 'h3C);
      chk("t6_vld", int'(bus.out_vld_o), 1);
      chk("t6_level", int'(bus.level_o), 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
